// File: rtl/gauss_5x5_pkg.sv
// Kernel taps, rounding constants and shift-add helpers shared by the 5x5 Gaussian stage.
// Pure declarations: no state, no latency, no flow control.
package gauss_5x5_pkg;

    localparam logic [2:0]  KTAP0      = 3'd1;
    localparam logic [2:0]  KTAP1      = 3'd4;
    localparam logic [2:0]  KTAP2      = 3'd6;
    localparam logic [2:0]  KTAP3      = 3'd4;
    localparam logic [2:0]  KTAP4      = 3'd1;
    localparam int unsigned SHIFT_C    = 8;
    localparam logic [16:0] ROUND_C    = 17'd128;
    localparam int          CENTER_IDX = 12;

    // Constant tap times x using only shifts and adds; taps never exceed 7.
    function automatic logic [15:0] tap_mul(input logic [15:0] x, input logic [2:0] tap);
        return (tap[0] ? x : 16'd0) + (tap[1] ? (x << 1) : 16'd0) + (tap[2] ? (x << 2) : 16'd0);
    endfunction

    function automatic logic [11:0] wsum5(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d,
                                          input logic [7:0] e);
        return 12'(tap_mul({8'd0, a}, KTAP0) + tap_mul({8'd0, b}, KTAP1) +
                   tap_mul({8'd0, c}, KTAP2) + tap_mul({8'd0, d}, KTAP3) +
                   tap_mul({8'd0, e}, KTAP4));
    endfunction

endpackage

// File: rtl/gauss_lane_5x5.sv
// One 8-bit lane of the separable 1-4-6-4-1 filter: column sums, row sum, round.
// Two registered stages; y_o is combinational from the second. Never stalls.
module gauss_lane_5x5
    import gauss_5x5_pkg::*;
(
    input  logic         clock,
    input  logic         rst_n,
    input  logic [199:0] win_i,
    output logic [7:0]   y_o
);

    logic [11:0] s_d [5];
    logic [11:0] s_q [5];
    logic [15:0] t_d;
    logic [15:0] t_q;
    logic [16:0] rnd;

    always_comb begin
        for (int c = 0; c < 5; c++) begin
            s_d[c] = wsum5(win_i[(0 + 5*c)*8 +: 8], win_i[(1 + 5*c)*8 +: 8],
                           win_i[(2 + 5*c)*8 +: 8], win_i[(3 + 5*c)*8 +: 8],
                           win_i[(4 + 5*c)*8 +: 8]);
        end
        t_d = tap_mul({4'd0, s_q[0]}, KTAP0) + tap_mul({4'd0, s_q[1]}, KTAP1) +
              tap_mul({4'd0, s_q[2]}, KTAP2) + tap_mul({4'd0, s_q[3]}, KTAP3) +
              tap_mul({4'd0, s_q[4]}, KTAP4);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 5; c++) s_q[c] <= '0;
            t_q <= '0;
        end else begin
            for (int c = 0; c < 5; c++) s_q[c] <= s_d[c];
            t_q <= t_d;
        end
    end

    // Full-scale t rounds to at most 255, so the low 8 bits of the quotient are exact.
    assign rnd = {1'b0, t_q} + ROUND_C;
    assign y_o = 8'(rnd >> SHIFT_C);

endmodule

// File: rtl/gauss_5x5.sv
// 5x5 Gaussian smoothing stage; border pixels and disabled frames pass the centre through.
// Fixed 3-clock latency, one pixel per clock, no backpressure.
module gauss_5x5
    import gauss_5x5_pkg::*;
#(
    parameter int DSIZE        = 24,
    parameter int VIDEO_WIDTH  = 1920,
    parameter int VIDEO_HEIGHT = 1080
)(
    input  logic               clock,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               invs,
    input  logic               inde,
    input  logic [DSIZE*25-1:0] indata,
    output logic               outvs,
    output logic               outde,
    output logic [DSIZE-1:0]   outdata
);

    localparam int LANES = DSIZE / 8;
    localparam int CW    = $clog2(VIDEO_WIDTH);
    localparam int RW    = $clog2(VIDEO_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(VIDEO_WIDTH - 1);
    localparam logic [CW-1:0] COL_LO  = CW'(2);
    localparam logic [CW-1:0] COL_HI  = CW'(VIDEO_WIDTH - 3);
    localparam logic [RW-1:0] ROW_MAX = RW'(VIDEO_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_LO  = RW'(2);
    localparam logic [RW-1:0] ROW_HI  = RW'(VIDEO_HEIGHT - 3);

    logic             invs_q, inde_q, en_frame_q, en_frame_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d, row_cur;
    logic             vs_rise, de_fall, border, sel_d;
    logic             vs1_q, de1_q, sel1_q, vs2_q, de2_q, sel2_q;
    logic [DSIZE-1:0] ctr1_q, ctr2_q, y_all, outdata_d;
    logic             outvs_q, outde_q;
    logic [DSIZE-1:0] outdata_q;

    // Position and frame-enable are resolved for the pixel on the inputs this cycle.
    always_comb begin
        vs_rise    = invs & ~invs_q;
        de_fall    = inde_q & ~inde;
        col_d      = '0;
        if (inde) col_d = (col_q == COL_MAX) ? col_q : col_q + CW'(1);
        row_cur    = vs_rise ? '0 : row_q;
        row_d      = row_cur;
        if (!vs_rise && de_fall && row_q != ROW_MAX) row_d = row_q + RW'(1);
        en_frame_d = vs_rise ? enable : en_frame_q;
        border     = (col_q < COL_LO) || (col_q > COL_HI) ||
                     (row_cur < ROW_LO) || (row_cur > ROW_HI);
        sel_d      = en_frame_d & ~border;
        outdata_d  = '0;
        if (de2_q) outdata_d = sel2_q ? y_all : ctr2_q;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            invs_q     <= 1'b0;
            inde_q     <= 1'b0;
            en_frame_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            vs1_q      <= 1'b0;
            de1_q      <= 1'b0;
            sel1_q     <= 1'b0;
            ctr1_q     <= '0;
            vs2_q      <= 1'b0;
            de2_q      <= 1'b0;
            sel2_q     <= 1'b0;
            ctr2_q     <= '0;
            outvs_q    <= 1'b0;
            outde_q    <= 1'b0;
            outdata_q  <= '0;
        end else begin
            invs_q     <= invs;
            inde_q     <= inde;
            en_frame_q <= en_frame_d;
            col_q      <= col_d;
            row_q      <= row_d;
            vs1_q      <= invs;
            de1_q      <= inde;
            sel1_q     <= sel_d;
            ctr1_q     <= indata[CENTER_IDX*DSIZE +: DSIZE];
            vs2_q      <= vs1_q;
            de2_q      <= de1_q;
            sel2_q     <= sel1_q;
            ctr2_q     <= ctr1_q;
            outvs_q    <= vs2_q;
            outde_q    <= de2_q;
            outdata_q  <= outdata_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [199:0] win;
        for (genvar k = 0; k < 25; k++) begin : g_tap
            assign win[k*8 +: 8] = indata[k*DSIZE + l*8 +: 8];
        end
        gauss_lane_5x5 u_lane (
            .clock (clock),
            .rst_n (rst_n),
            .win_i (win),
            .y_o   (y_all[l*8 +: 8])
        );
    end

    assign outvs   = outvs_q;
    assign outde   = outde_q;
    assign outdata = outdata_q;

endmodule

// File: tb/tb_gauss_5x5.sv
// Directed bench for gauss_5x5 on a 16x8 frame: hand-computed windows, 3-cycle expected pipe.
module tb_gauss_5x5;

    localparam int DS = 24;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int NP = 6;

    logic             clock   = 1'b0;
    logic             rst_n   = 1'b0;
    logic             enable  = 1'b0;
    logic             invs    = 1'b0;
    logic             inde    = 1'b0;
    logic [DS*25-1:0] indata  = '0;
    logic             outvs, outde;
    logic [DS-1:0]    outdata;

    gauss_5x5 #(.DSIZE(DS), .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H)) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .enable  (enable),
        .invs    (invs),
        .inde    (inde),
        .indata  (indata),
        .outvs   (outvs),
        .outde   (outde),
        .outdata (outdata)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    logic [DS*25-1:0] pat_win  [NP];
    logic [DS-1:0]    pat_filt [NP];
    logic [DS-1:0]    pat_ctr  [NP];

    logic          cur_vs = 1'b0, cur_de = 1'b0;
    logic [DS-1:0] cur_dat = '0;
    logic          ep_vs [3];
    logic          ep_de [3];
    logic [DS-1:0] ep_dat [3];
    logic          chk_on = 1'b0, en_exp = 1'b0, vs_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ep_vs[i]  <= 1'b0;
                ep_de[i]  <= 1'b0;
                ep_dat[i] <= '0;
            end
        end else begin
            ep_vs[0]  <= cur_vs;   ep_vs[1]  <= ep_vs[0];  ep_vs[2]  <= ep_vs[1];
            ep_de[0]  <= cur_de;   ep_de[1]  <= ep_de[0];  ep_de[2]  <= ep_de[1];
            ep_dat[0] <= cur_dat;  ep_dat[1] <= ep_dat[0]; ep_dat[2] <= ep_dat[1];
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("outvs",   {31'd0, outvs},  {31'd0, ep_vs[2]});
            chk("outde",   {31'd0, outde},  {31'd0, ep_de[2]});
            chk("outdata", {8'd0, outdata}, {8'd0, ep_dat[2]});
        end
    end

    task automatic set_px(input int p, input int r, input int c, input int lane, input logic [7:0] v);
        pat_win[p][(r + 5*c)*DS + lane*8 +: 8] = v;
    endtask

    // One clock of stimulus; row/col are the bench's own idea of where the pixel sits.
    task automatic px(input logic vs, input logic de, input int row, input int col, input int off);
        int   p;
        logic interior;
        p = (row + col + off) % NP;
        if (vs && !vs_prev) en_exp = enable;
        vs_prev  = vs;
        invs     = vs;
        inde     = de;
        indata   = de ? pat_win[p] : '0;
        interior = (col >= 2) && (col <= W - 3) && (row >= 2) && (row <= H - 3);
        cur_vs   = vs;
        cur_de   = de;
        cur_dat  = !de ? '0 : ((en_exp && interior) ? pat_filt[p] : pat_ctr[p]);
        @(posedge clock);
        #1;
    endtask

    task automatic line(input int row, input int npix, input int off, input logic vs_head, input logic vs_tail);
        for (int c = 0; c < npix; c++) px(vs_head && c < 2, 1'b1, row, c, off);
        for (int b = 0; b < 4; b++) px(vs_tail && b < 2, 1'b0, row, 0, off);
    endtask

    task automatic vs_lead(input int off);
        for (int b = 0; b < 4; b++) px(b < 2, 1'b0, 0, 0, off);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) pat_win[p] = '0;
        for (int k = 0; k < 25; k++) begin
            for (int l = 0; l < 3; l++) begin
                set_px(0, k % 5, k / 5, l, 8'd100);
                set_px(2, k % 5, k / 5, l, 8'd255);
            end
            set_px(3, k % 5, k / 5, 1, 8'd50);
            set_px(3, k % 5, k / 5, 2, 8'd50);
        end
        for (int l = 0; l < 3; l++) set_px(1, 2, 2, l, 8'd255);
        set_px(3, 2, 2, 0, 8'd255);
        set_px(4, 0, 0, 0, 8'd128);
        set_px(4, 0, 0, 1, 8'd127);
        set_px(4, 2, 2, 2, 8'd200);
        set_px(5, 1, 0, 0, 8'd200);
        set_px(5, 2, 1, 1, 8'd100);
        set_px(5, 3, 3, 2, 8'd255);
        pat_filt[0] = 24'h646464;  pat_ctr[0] = 24'h646464;
        pat_filt[1] = 24'h242424;  pat_ctr[1] = 24'hFFFFFF;
        pat_filt[2] = 24'hFFFFFF;  pat_ctr[2] = 24'hFFFFFF;
        pat_filt[3] = 24'h323224;  pat_ctr[3] = 24'h3232FF;
        pat_filt[4] = 24'h1C0001;  pat_ctr[4] = 24'hC80000;
        pat_filt[5] = 24'h100903;  pat_ctr[5] = 24'h000000;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_outvs",   {31'd0, outvs},  32'd0);
        chk("rst_outde",   {31'd0, outde},  32'd0);
        chk("rst_outdata", {8'd0, outdata}, 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        enable = 1'b1;

        // Partial frame straight out of reset: no frame start seen yet.
        for (int r = 0; r < 4; r++) line(r, W, 0, 1'b0, 1'b0);

        // Filtered frame; enable dropped mid-frame must not take effect.
        vs_lead(1);
        for (int r = 0; r < 4; r++) line(r, W, 1, 1'b0, 1'b0);
        enable = 1'b0;
        for (int r = 4; r < H; r++) line(r, W, 1, 1'b0, 1'b0);

        // Frame started with enable low: all passthrough.
        vs_lead(2);
        enable = 1'b1;
        for (int r = 0; r < H; r++) line(r, W, 2, 1'b0, 1'b0);

        // Oversize line and extra row; frame sync rises on the last line's de fall.
        vs_lead(3);
        for (int r = 0; r <= H; r++) line(r, (r == 3) ? W + 2 : W, 3, 1'b0, r == H);
        for (int r = 0; r < H; r++) line(r, W, 4, 1'b0, 1'b0);

        // Frame sync rising together with the first pixel of row 0.
        line(0, W, 5, 1'b1, 1'b0);
        for (int r = 1; r < H; r++) line(r, W, 5, 1'b0, 1'b0);

        // Reset in the middle of a line.
        vs_lead(0);
        for (int r = 0; r < 3; r++) line(r, W, 0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) px(1'b0, 1'b1, 3, c, 0);
        #2;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_outvs",   {31'd0, outvs},  32'd0);
        chk("midrst_outde",   {31'd0, outde},  32'd0);
        chk("midrst_outdata", {8'd0, outdata}, 32'd0);
        invs = 1'b0; inde = 1'b0; indata = '0;
        cur_vs = 1'b0; cur_de = 1'b0; cur_dat = '0;
        vs_prev = 1'b0; en_exp = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("inrst_outde",   {31'd0, outde},  32'd0);
        chk("inrst_outdata", {8'd0, outdata}, 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        for (int r = 0; r < 4; r++) line(r, W, 1, 1'b0, 1'b0);
        vs_lead(2);
        for (int r = 0; r < H; r++) line(r, W, 2, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) px(1'b0, 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
